// File: rtl/keypad_number_entry.sv
// Assembles keypad digit presses into a BCD number with backspace/clear/enter and
// hands the committed number downstream over a valid/ready handshake.
module keypad_number_entry #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           key_edge,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [4*DIGITS-1:0]   buf_bcd,
  output logic [3:0]            digit_cnt,
  output logic                  busy,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic {S_ENTRY, S_HOLD} state_t;

  state_t          r_state, w_state_next;
  logic [BW-1:0]   r_buf, w_buf_next;
  logic [BW-1:0]   r_out_bcd, w_out_bcd_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            r_valid, w_valid_next;
  logic            r_err, w_err_next;

  logic            w_multi;
  logic            w_is_digit;
  logic [3:0]      w_digit;

  // Clearing the lowest set bit leaves something only when two or more keys fired together.
  assign w_multi    = (key_edge & (key_edge - 16'd1)) != 16'd0;
  assign w_is_digit = (key_edge[9:0] != 10'd0) && !w_multi;

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_edge[i]) w_digit = 4'(i);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_buf_next     = r_buf;
    w_cnt_next     = r_cnt;
    w_out_bcd_next = r_out_bcd;
    w_valid_next   = r_valid;
    w_err_next     = 1'b0;

    if (r_state == S_HOLD) begin
      if (key_edge != 16'd0) w_err_next = 1'b1;
      if (r_valid && out_ready) begin
        w_valid_next = 1'b0;
        w_state_next = S_ENTRY;
      end
    end else if (w_multi) begin
      w_err_next = 1'b1;
    end else if (w_is_digit) begin
      if (r_cnt < 4'(DIGITS)) begin
        w_buf_next = (r_buf << 4) | BW'(w_digit);
        w_cnt_next = r_cnt + 4'd1;
      end else begin
        w_err_next = 1'b1;
      end
    end else if (key_edge[10]) begin
      if (r_cnt != 4'd0) begin
        w_buf_next = r_buf >> 4;
        w_cnt_next = r_cnt - 4'd1;
      end else begin
        w_err_next = 1'b1;
      end
    end else if (key_edge[11]) begin
      w_buf_next = '0;
      w_cnt_next = 4'd0;
    end else if (key_edge[12]) begin
      if (r_cnt != 4'd0) begin
        w_out_bcd_next = r_buf;
        w_valid_next   = 1'b1;
        w_buf_next     = '0;
        w_cnt_next     = 4'd0;
        w_state_next   = S_HOLD;
      end else begin
        w_err_next = 1'b1;
      end
    end
    // Keys 13-15 alone fall through with no effect.
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_ENTRY;
      r_buf     <= '0;
      r_cnt     <= 4'd0;
      r_out_bcd <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_buf     <= w_buf_next;
      r_cnt     <= w_cnt_next;
      r_out_bcd <= w_out_bcd_next;
      r_valid   <= w_valid_next;
      r_err     <= w_err_next;
    end
  end

  assign out_valid = r_valid;
  assign out_bcd   = r_out_bcd;
  assign buf_bcd   = r_buf;
  assign digit_cnt = r_cnt;
  assign busy      = (r_state == S_HOLD);
  assign err       = r_err;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed scenarios plus a randomized run, checked against a digit-queue model of number entry.
module tb_keypad_number_entry;

  localparam int DIGITS = 4;
  localparam int BW = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   key_edge = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [BW-1:0] out_bcd;
  logic [BW-1:0] buf_bcd;
  logic [3:0]    digit_cnt;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: entered digits oldest first, plus commit/hold status.
  int          m_digits[$];
  bit          m_hold;
  bit [BW-1:0] m_out;
  bit          m_err;

  keypad_number_entry #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .key_edge(key_edge), .out_ready(out_ready),
    .out_valid(out_valid), .out_bcd(out_bcd), .buf_bcd(buf_bcd),
    .digit_cnt(digit_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit [BW-1:0] m_value();
    bit [BW-1:0] v = '0;
    foreach (m_digits[k]) v = v * 16 + BW'(m_digits[k]);
    return v;
  endfunction

  function automatic void model_update(input logic [15:0] k, input logic rdy, input logic rs);
    int  key_idx;
    bit  handshake;
    if (!rs) begin
      m_digits.delete(); m_hold = 0; m_out = '0; m_err = 0;
      return;
    end
    handshake = m_hold && rdy;
    m_err = 0;
    if (k != 0 && ($countones(k) > 1 || m_hold)) begin
      m_err = 1;
    end else if (k != 0) begin
      key_idx = 0;
      for (int i = 0; i < 16; i++) if (k[i]) key_idx = i;
      if (key_idx < 10) begin
        if (m_digits.size() < DIGITS) m_digits.push_back(key_idx); else m_err = 1;
      end else if (key_idx == 10) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back()); else m_err = 1;
      end else if (key_idx == 11) begin
        m_digits.delete();
      end else if (key_idx == 12) begin
        if (m_digits.size() > 0) begin
          m_out = m_value(); m_hold = 1; m_digits.delete();
        end else m_err = 1;
      end
    end
    if (handshake) m_hold = 0;
  endfunction

  task automatic step(input logic [15:0] k, input logic rdy, input logic rs);
    key_edge = k; out_ready = rdy; rst = rs;
    @(posedge clk);
    model_update(k, rdy, rs);
    #1;
    key_edge = '0;
  endtask

  function automatic logic [15:0] key(input int i);
    return 16'd1 << i;
  endfunction

  task automatic test_reset();
    step(16'h0000, 1'b0, 1'b0);
    step(key(5), 1'b0, 1'b0);
    n_checks++;
    if ({out_valid, out_bcd, buf_bcd, digit_cnt, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b out=%h buf=%h cnt=%0d busy=%0b err=%0b, required all zero",
               out_valid, out_bcd, buf_bcd, digit_cnt, busy, err);
    end
  endtask

  task automatic test_commit();
    int errs = 0;
    step(key(1), 1'b1, 1'b1); errs += int'(err);
    step(key(2), 1'b1, 1'b1); errs += int'(err);
    step(key(3), 1'b1, 1'b1); errs += int'(err);
    n_checks++;
    if (buf_bcd !== 16'h0123 || digit_cnt !== 4'd3) begin
      n_fail++; $display("FAIL commit_buf: buf=%h cnt=%0d, required 0123 cnt 3", buf_bcd, digit_cnt);
    end
    step(key(12), 1'b1, 1'b1); errs += int'(err);
    n_checks++;
    if (out_valid !== 1'b1 || out_bcd !== 16'h0123 || busy !== 1'b1 || buf_bcd !== 16'h0 || digit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL commit_out: valid=%0b out=%h busy=%0b buf=%h cnt=%0d, required 1 0123 1 0000 0",
                         out_valid, out_bcd, busy, buf_bcd, digit_cnt);
    end
    step(16'h0000, 1'b1, 1'b1); errs += int'(err);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== 16'h0123) begin
      n_fail++; $display("FAIL commit_handshake: valid=%0b busy=%0b out=%h, required 0 0 0123", out_valid, busy, out_bcd);
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL commit_no_err: err pulses=%0d, required 0", errs);
    end
  endtask

  task automatic test_overflow();
    int errs = 0;
    step(key(9), 1'b0, 1'b1); errs += int'(err);
    step(key(8), 1'b0, 1'b1); errs += int'(err);
    step(key(7), 1'b0, 1'b1); errs += int'(err);
    step(key(6), 1'b0, 1'b1); errs += int'(err);
    step(key(5), 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1 || errs != 0) begin
      n_fail++; $display("FAIL overflow_err: fifth err=%0b earlier=%0d, required 1 and 0", err, errs);
    end
    n_checks++;
    if (buf_bcd !== 16'h9876 || digit_cnt !== 4'd4) begin
      n_fail++; $display("FAIL overflow_buf: buf=%h cnt=%0d, required 9876 cnt 4", buf_bcd, digit_cnt);
    end
    step(16'h0000, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL overflow_err_width: err=%0b, required 0", err);
    end
    step(key(11), 1'b0, 1'b1);
  endtask

  task automatic test_backspace();
    step(key(4), 1'b1, 1'b1);
    step(key(5), 1'b1, 1'b1);
    step(key(10), 1'b1, 1'b1);
    n_checks++;
    if (buf_bcd !== 16'h0004 || digit_cnt !== 4'd1) begin
      n_fail++; $display("FAIL bksp_buf: buf=%h cnt=%0d, required 0004 cnt 1", buf_bcd, digit_cnt);
    end
    step(key(12), 1'b1, 1'b1);
    n_checks++;
    if (out_bcd !== 16'h0004 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bksp_commit: out=%h valid=%0b, required 0004 1", out_bcd, out_valid);
    end
    step(16'h0000, 1'b1, 1'b1);
    step(key(10), 1'b1, 1'b1);
    n_checks++;
    if (err !== 1'b1 || digit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL bksp_empty: err=%0b cnt=%0d, required 1 0", err, digit_cnt);
    end
    step(key(12), 1'b1, 1'b1);
    n_checks++;
    if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL enter_empty: err=%0b valid=%0b busy=%0b, required 1 0 0", err, out_valid, busy);
    end
  endtask

  task automatic test_illegal();
    step(key(1), 1'b0, 1'b1);
    step(16'h0003, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1 || buf_bcd !== 16'h0001 || digit_cnt !== 4'd1) begin
      n_fail++; $display("FAIL multi_key: err=%0b buf=%h cnt=%0d, required 1 0001 1", err, buf_bcd, digit_cnt);
    end
    step(key(13), 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b0 || buf_bcd !== 16'h0001 || digit_cnt !== 4'd1) begin
      n_fail++; $display("FAIL unused_key: err=%0b buf=%h cnt=%0d, required 0 0001 1", err, buf_bcd, digit_cnt);
    end
    step(key(11), 1'b0, 1'b1);
    step(key(11), 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b0 || buf_bcd !== 16'h0000 || digit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL clear_empty: err=%0b buf=%h cnt=%0d, required 0 0000 0", err, buf_bcd, digit_cnt);
    end
    step(key(0), 1'b0, 1'b1);
    step(key(0), 1'b0, 1'b1);
    n_checks++;
    if (buf_bcd !== 16'h0000 || digit_cnt !== 4'd2) begin
      n_fail++; $display("FAIL leading_zeros: buf=%h cnt=%0d, required 0000 2", buf_bcd, digit_cnt);
    end
    step(key(11), 1'b0, 1'b1);
  endtask

  task automatic test_hold();
    int drops = 0;
    step(key(7), 1'b0, 1'b1);
    step(key(12), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(16'h0000, 1'b0, 1'b1);
      if (out_valid !== 1'b1 || out_bcd !== 16'h0007) drops++;
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++; $display("FAIL hold_stable: cycles lost=%0d, required 0", drops);
    end
    step(key(8), 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1 || out_valid !== 1'b1 || out_bcd !== 16'h0007 || busy !== 1'b1 || buf_bcd !== 16'h0) begin
      n_fail++; $display("FAIL hold_key: err=%0b valid=%0b out=%h busy=%0b buf=%h, required 1 1 0007 1 0000",
                         err, out_valid, out_bcd, busy, buf_bcd);
    end
    step(16'h0000, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== 16'h0007) begin
      n_fail++; $display("FAIL hold_release: valid=%0b busy=%0b out=%h, required 0 0 0007", out_valid, busy, out_bcd);
    end
    step(key(8), 1'b0, 1'b1);
    n_checks++;
    if (buf_bcd !== 16'h0008 || err !== 1'b0) begin
      n_fail++; $display("FAIL hold_after: buf=%h err=%0b, required 0008 0", buf_bcd, err);
    end
    step(key(11), 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    step(16'h0300, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: err=%0b, required 1", err);
    end
    step(16'h1010, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1 || digit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL b2b_second: err=%0b cnt=%0d, required 1 0", err, digit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step(key(1), 1'b0, 1'b1);
    step(key(2), 1'b0, 1'b1);
    step(16'h0003, 1'b0, 1'b0);
    n_checks++;
    if ({out_valid, out_bcd, buf_bcd, digit_cnt, busy, err} !== '0) begin
      n_fail++; $display("FAIL reset_entry: valid=%0b out=%h buf=%h cnt=%0d busy=%0b err=%0b, required all zero",
                         out_valid, out_bcd, buf_bcd, digit_cnt, busy, err);
    end
    step(key(3), 1'b0, 1'b1);
    step(key(12), 1'b0, 1'b1);
    step(key(4), 1'b0, 1'b0);
    n_checks++;
    if ({out_valid, out_bcd, buf_bcd, digit_cnt, busy, err} !== '0) begin
      n_fail++; $display("FAIL reset_hold: valid=%0b out=%h buf=%h cnt=%0d busy=%0b err=%0b, required all zero",
                         out_valid, out_bcd, buf_bcd, digit_cnt, busy, err);
    end
    step(key(5), 1'b0, 1'b1);
    n_checks++;
    if (buf_bcd !== 16'h0005 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_resume: buf=%h busy=%0b, required 0005 0", buf_bcd, busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    logic        rdy, rs;
    int          sel;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 5)       k = 16'h0000;
      else if (sel < 14) k = key($urandom_range(0, 9));
      else if (sel < 18) k = key($urandom_range(10, 15));
      else               k = 16'($urandom);
      rdy = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 149) != 0);
      step(k, rdy, rs);
      n_checks++;
      if ({out_valid, out_bcd, buf_bcd, digit_cnt, busy, err} !==
          {m_hold, m_out, m_value(), 4'(m_digits.size()), m_hold, m_err}) begin
        n_fail++;
        $display("FAIL random[%0d] key=%h rdy=%0b rst=%0b: got v=%0b o=%h b=%h c=%0d busy=%0b e=%0b, required v=%0b o=%h b=%h c=%0d busy=%0b e=%0b",
                 n, k, rdy, rs, out_valid, out_bcd, buf_bcd, digit_cnt, busy, err,
                 m_hold, m_out, m_value(), m_digits.size(), m_hold, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_overflow();
    test_backspace();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
